// File: rtl/kamacore_datatypes_pkg.sv
// Shared kamacore types: memory-arbiter FSM states, port-owner tags and bus widths.
package kamacore_datatypes;

  localparam int CPU_WIDTH    = 32;
  localparam int MEM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IF,
    OWNER_D
  } mem_owner_e;

endpackage

// File: rtl/kamacore_mem_arb_pick.sv
// Combinational winner selection for the memory port: data by default,
// fetch when data is idle or the fetch has been starved STARVE_LIMIT times.
module kamacore_mem_arb_pick
  import kamacore_datatypes::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int STREAK_W     = 2
) (
  input  logic                if_req_i,
  input  logic                d_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output mem_owner_e          winner_o
);

  logic starved;

  assign starved = (streak_i == STREAK_W'(STARVE_LIMIT));

  always_comb begin
    winner_o = OWNER_NONE;
    if (if_req_i && (!d_req_i || starved)) begin
      winner_o = OWNER_IF;
    end else if (d_req_i) begin
      winner_o = OWNER_D;
    end
  end

endmodule

// File: rtl/kamacore_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// tracks the fixed-latency response and routes it back to its owner.
module kamacore_mem_arbiter #(
  parameter int CPU_WIDTH    = kamacore_datatypes::CPU_WIDTH,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    if_req,
  input  logic [CPU_WIDTH-1:0]                    if_addr,
  output logic                                    if_gnt,
  output logic                                    if_rvalid,
  output logic [CPU_WIDTH-1:0]                    if_rdata,
  input  logic                                    flush_if,
  input  logic                                    d_req,
  input  logic                                    d_we,
  input  logic [CPU_WIDTH-1:0]                    d_addr,
  input  logic [CPU_WIDTH-1:0]                    d_wdata,
  input  logic [kamacore_datatypes::MEM_BE_WIDTH-1:0] d_be,
  output logic                                    d_gnt,
  output logic                                    d_rvalid,
  output logic [CPU_WIDTH-1:0]                    d_rdata,
  output logic                                    m_req,
  output logic                                    m_we,
  output logic [CPU_WIDTH-1:0]                    m_addr,
  output logic [CPU_WIDTH-1:0]                    m_wdata,
  output logic [kamacore_datatypes::MEM_BE_WIDTH-1:0] m_be,
  input  logic [CPU_WIDTH-1:0]                    m_rdata
);

  import kamacore_datatypes::*;

  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STREAK_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_e          state_q, state_d;
  mem_owner_e          owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  logic                store_q, store_d;

  mem_owner_e winner;
  logic       window;
  logic       resp;

  kamacore_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STREAK_W     (STREAK_W)
  ) u_pick (
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .streak_i (streak_q),
    .winner_o (winner)
  );

  // Grants are held off while reset is asserted so every output reads 0.
  assign window = rst && (state_q != ARB_WAIT);
  assign if_gnt = window && (winner == OWNER_IF);
  assign d_gnt  = window && (winner == OWNER_D);

  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (if_gnt) begin
      m_req  = 1'b1;
      m_addr = if_addr;
      m_be   = '1;
    end else if (d_gnt) begin
      m_req   = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end
  end

  assign resp      = (state_q == ARB_RESP);
  assign if_rvalid = resp && (owner_q == OWNER_IF) && !drop_q && !flush_if;
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign d_rvalid  = resp && (owner_q == OWNER_D);
  assign d_rdata   = (d_rvalid && !store_q) ? m_rdata : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    drop_d   = drop_q;
    store_d  = store_q;

    case (state_q)
      ARB_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ARB_RESP;
        end
        if (flush_if && (owner_q == OWNER_IF)) begin
          drop_d = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        owner_d = OWNER_NONE;
        drop_d  = 1'b0;
        store_d = 1'b0;
      end
      default: ;
    endcase

    // A grant in RESP overrides the return to IDLE (back-to-back issue).
    if (if_gnt || d_gnt) begin
      state_d = (MEM_LATENCY == 1) ? ARB_RESP : ARB_WAIT;
      cnt_d   = CNT_W'(MEM_LATENCY - 1);
      owner_d = if_gnt ? OWNER_IF : OWNER_D;
      store_d = d_gnt && d_we;
      drop_d  = if_gnt && flush_if;
    end

    if (if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && if_req && (streak_q != STREAK_W'(STARVE_LIMIT))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_NONE;
      cnt_q    <= '0;
      streak_q <= '0;
      drop_q   <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      store_q  <= store_d;
    end
  end

endmodule

// File: tb/tb_kamacore_mem_arbiter.sv
// Self-checking bench for kamacore_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_kamacore_mem_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int LIMIT = 3;

  logic         clk;
  logic         rst;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_gnt;
  logic         if_rvalid;
  logic [W-1:0] if_rdata;
  logic         flush_if;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic [3:0]   d_be;
  logic         d_gnt;
  logic         d_rvalid;
  logic [W-1:0] d_rdata;
  logic         m_req;
  logic         m_we;
  logic [W-1:0] m_addr;
  logic [W-1:0] m_wdata;
  logic [3:0]   m_be;
  logic [W-1:0] m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  kamacore_mem_arbiter #(
    .CPU_WIDTH    (W),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .flush_if  (flush_if),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_rdata   (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    flush_if = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_be     = '0;
    m_rdata  = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    idle_inputs();
    repeat (n) next_cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst    = 1'b0;
    if_req = 1'b1;
    d_req  = 1'b1;
    d_addr = 32'h44;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, d_gnt, m_req, m_addr, if_rvalid, d_rvalid} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b/%b m_req=%b m_addr=%h rvalid=%b/%b required all 0",
               if_gnt, d_gnt, m_req, m_addr, if_rvalid, d_rvalid);
    end
    next_cyc();
    idle_inputs();
    rst = 1'b1;
    settle(3);
  endtask

  task automatic test_idle_fetch();
    logic [W-1:0] r;
    r = $urandom;
    if_req  = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || m_req !== 1'b1 || m_addr !== 32'h100 ||
        m_we !== 1'b0 || m_be !== 4'hF) begin
      n_err++;
      $display("FAIL idle_fetch_grant: if_gnt=%b d_gnt=%b m_req=%b m_addr=%h m_we=%b m_be=%h required 1 0 1 00000100 0 f",
               if_gnt, d_gnt, m_req, m_addr, m_we, m_be);
    end
    next_cyc();
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b0 || if_rvalid !== 1'b0 || m_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_fetch_wait: if_gnt=%b if_rvalid=%b m_req=%b required 0 0 0",
               if_gnt, if_rvalid, m_req);
    end
    next_cyc();
    m_rdata = r;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b1 || if_rdata !== r || d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_fetch_resp: if_rvalid=%b if_rdata=%h d_rvalid=%b required 1 %h 0",
               if_rvalid, if_rdata, d_rvalid, r);
    end
    next_cyc();
    m_rdata = '0;
    d_req   = 1'b1;
    d_addr  = 32'h204;
    d_be    = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_fetch_back_to_idle: d_gnt=%b if_rvalid=%b required 1 0", d_gnt, if_rvalid);
    end
    next_cyc();
    settle(3);
  endtask

  task automatic test_contention();
    logic [W-1:0] r1, r2;
    r1 = $urandom;
    r2 = $urandom;
    if_req  = 1'b1;
    if_addr = 32'h300;
    d_req   = 1'b1;
    d_addr  = 32'h200;
    d_be    = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || m_addr !== 32'h200) begin
      n_err++;
      $display("FAIL contention_first: d_gnt=%b if_gnt=%b m_addr=%h required 1 0 00000200",
               d_gnt, if_gnt, m_addr);
    end
    next_cyc();
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b0 || m_req !== 1'b0) begin
      n_err++;
      $display("FAIL contention_hold: if_gnt=%b m_req=%b required 0 0", if_gnt, m_req);
    end
    next_cyc();
    m_rdata = r1;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_rdata !== r1 || if_gnt !== 1'b1 || m_addr !== 32'h300) begin
      n_err++;
      $display("FAIL contention_resp_grant: d_rvalid=%b d_rdata=%h if_gnt=%b m_addr=%h required 1 %h 1 00000300",
               d_rvalid, d_rdata, if_gnt, m_addr, r1);
    end
    next_cyc();
    if_req  = 1'b0;
    m_rdata = '0;
    next_cyc();
    m_rdata = r2;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b1 || if_rdata !== r2 || d_rvalid !== 1'b0 || d_rdata !== '0) begin
      n_err++;
      $display("FAIL contention_if_resp: if_rvalid=%b if_rdata=%h d_rvalid=%b d_rdata=%h required 1 %h 0 0",
               if_rvalid, if_rdata, d_rvalid, d_rdata, r2);
    end
    next_cyc();
    settle(3);
  endtask

  task automatic test_starvation();
    // Expected grant order with both requests held: data LIMIT times, then fetch.
    if_req  = 1'b1;
    if_addr = 32'h1000;
    d_req   = 1'b1;
    d_addr  = 32'h2000;
    d_be    = 4'hF;
    for (int c = 0; c < 16; c++) begin
      logic exp_if, exp_d;
      int   k;
      k      = c / 2;
      exp_if = (c % 2 == 0) && (k % (LIMIT + 1) == LIMIT);
      exp_d  = (c % 2 == 0) && !exp_if;
      @(negedge clk);
      n_cmp++;
      if (if_gnt !== exp_if || d_gnt !== exp_d) begin
        n_err++;
        $display("FAIL starvation_c%0d: if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, exp_if, exp_d);
      end
      next_cyc();
    end
    settle(4);
  endtask

  task automatic test_flush();
    logic [W-1:0] r;
    r = $urandom;
    if_req  = 1'b1;
    if_addr = 32'h400;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_grant: if_gnt=%b required 1", if_gnt);
    end
    next_cyc();
    if_req   = 1'b0;
    flush_if = 1'b1;
    next_cyc();
    flush_if = 1'b0;
    d_req    = 1'b1;
    d_addr   = 32'h500;
    d_be     = 4'hF;
    m_rdata  = 32'hA5A5_5A5A;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b0 || if_rdata !== '0 || d_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_suppress: if_rvalid=%b if_rdata=%h d_gnt=%b required 0 0 1",
               if_rvalid, if_rdata, d_gnt);
    end
    next_cyc();
    d_req = 1'b0;
    next_cyc();
    m_rdata = r;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_rdata !== r) begin
      n_err++;
      $display("FAIL flush_data_resp: d_rvalid=%b d_rdata=%h required 1 %h", d_rvalid, d_rdata, r);
    end
    next_cyc();
    m_rdata  = '0;
    if_req   = 1'b1;
    if_addr  = 32'h480;
    flush_if = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL flush_same_cycle_grant: if_gnt=%b required 1", if_gnt);
    end
    next_cyc();
    if_req   = 1'b0;
    flush_if = 1'b0;
    next_cyc();
    m_rdata = $urandom;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_same_cycle_drop: if_rvalid=%b required 0", if_rvalid);
    end
    next_cyc();
    settle(3);
  endtask

  task automatic test_store();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h600;
    d_wdata = 32'hCAFE_0011;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1 || m_we !== 1'b1 || m_be !== 4'b0011 || m_addr !== 32'h600 ||
        m_wdata !== 32'hCAFE_0011) begin
      n_err++;
      $display("FAIL store_grant: d_gnt=%b m_we=%b m_be=%b m_addr=%h m_wdata=%h required 1 1 0011 00000600 cafe0011",
               d_gnt, m_we, m_be, m_addr, m_wdata);
    end
    next_cyc();
    d_req = 1'b0;
    d_we  = 1'b0;
    next_cyc();
    m_rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid !== 1'b1 || d_rdata !== '0 || if_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL store_ack: d_rvalid=%b d_rdata=%h if_rvalid=%b required 1 0 0",
               d_rvalid, d_rdata, if_rvalid);
    end
    next_cyc();
    settle(3);
  endtask

  task automatic test_reset_mid_wait();
    if_req  = 1'b1;
    if_addr = 32'h700;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_grant: if_gnt=%b required 1", if_gnt);
    end
    next_cyc();
    if_req = 1'b0;
    d_req  = 1'b1;
    d_addr = 32'h800;
    d_be   = 4'hF;
    rst    = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt, d_gnt, m_req, m_we, m_addr, m_wdata, m_be, if_rvalid, if_rdata, d_rvalid, d_rdata} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: gnt=%b/%b m_req=%b m_addr=%h rvalid=%b/%b required all 0",
               if_gnt, d_gnt, m_req, m_addr, if_rvalid, d_rvalid);
    end
    next_cyc();
    m_rdata = 32'hFFFF_0000;
    @(negedge clk);
    n_cmp++;
    if (if_rvalid !== 1'b0 || d_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_held: if_rvalid=%b d_gnt=%b required 0 0", if_rvalid, d_gnt);
    end
    next_cyc();
    d_req = 1'b0;
    rst   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_no_resp_%0d: if_rvalid=%b d_rvalid=%b required 0 0", c, if_rvalid, d_rvalid);
      end
      next_cyc();
    end
    if_req  = 1'b1;
    if_addr = 32'h900;
    @(negedge clk);
    n_cmp++;
    if (if_gnt !== 1'b1 || m_addr !== 32'h900) begin
      n_err++;
      $display("FAIL rst_mid_first_req: if_gnt=%b m_addr=%h required 1 00000900", if_gnt, m_addr);
    end
    next_cyc();
    settle(4);
  endtask

  task automatic test_random();
    // Model: one outstanding transaction with a countdown to its response cycle.
    int busy, rem, own, st_we, dropped, streak;
    logic g_if, g_d;
    busy = 0; rem = 0; own = 0; st_we = 0; dropped = 0; streak = 0;
    g_if = 1'b0; g_d = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [137:0] exp_v, act_v;
      logic         resp_now, window, e_if_rv, e_d_rv;
      logic         e_req, e_we;
      logic [W-1:0] e_addr, e_wdata;
      logic [3:0]   e_be;
      int           win;
      if (g_if) if_req = 1'b0;
      if (g_d)  d_req  = 1'b0;
      if (!if_req && ($urandom % 3 == 0)) begin
        if_req  = 1'b1;
        if_addr = $urandom;
      end
      if (!d_req && ($urandom % 2 == 0)) begin
        d_req   = 1'b1;
        d_we    = $urandom % 2;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = $urandom;
      end
      flush_if = ($urandom % 8 == 0);
      m_rdata  = $urandom;

      resp_now = busy && (rem == 0);
      window   = !busy || resp_now;
      win = 0;
      if (window) begin
        if (if_req && (!d_req || streak == LIMIT)) win = 1;
        else if (d_req) win = 2;
      end
      e_if_rv = resp_now && own == 1 && !dropped && !flush_if;
      e_d_rv  = resp_now && own == 2;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      if (win == 1) begin
        e_req = 1'b1; e_addr = if_addr; e_be = 4'hF;
      end else if (win == 2) begin
        e_req = 1'b1; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
      end
      exp_v = {win == 1, e_if_rv, e_if_rv ? m_rdata : 32'h0,
               win == 2, e_d_rv, (e_d_rv && st_we == 0) ? m_rdata : 32'h0,
               e_req, e_we, e_addr, e_wdata, e_be};

      @(negedge clk);
      act_v = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_be};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random_c%0d: outputs=%h required %h", c, act_v, exp_v);
      end

      if (busy && own == 1 && flush_if) dropped = 1;
      if (win != 0) begin
        busy    = 1;
        rem     = LAT - 1;
        own     = win;
        st_we   = (win == 2) && d_we;
        dropped = (win == 1) && flush_if;
        if (win == 1) streak = 0;
        else if (if_req && streak < LIMIT) streak++;
      end else if (resp_now) begin
        busy = 0;
        own  = 0;
      end else if (busy) begin
        rem--;
      end
      g_if = (win == 1);
      g_d  = (win == 2);
      next_cyc();
    end
    settle(4);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_idle_fetch();
    test_contention();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kamacore_mem_arbiter.md
# kamacore_mem_arbiter

Shares the single kamacore memory port between the IF stage (instruction fetch) and the MEM stage (load/store). Grants one request per transaction, tracks the fixed-latency response and routes read data back to its owner. Drops in-flight fetches on branch redirect and prevents fetch starvation under back-to-back data traffic. Sits between the IF/MEM stages and `kamacore_memory`.

## Interface
- `CPU_WIDTH`, package value (32), address/data width.
- `MEM_LATENCY`, 2, cycles from grant to response; legal values are 1 or more.
- `STARVE_LIMIT`, 3, maximum consecutive contended data grants before a pending fetch is forced through; legal values are 1 or more.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  CPU_WIDTH  fetch address.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  CPU_WIDTH  fetch data.
- `flush_if`  in  1  branch redirect; kills any outstanding fetch.
- `d_req`  in  1  data request; held until granted.
- `d_we`  in  1  store when 1, load when 0.
- `d_addr`  in  CPU_WIDTH  data address.
- `d_wdata`  in  CPU_WIDTH  store data.
- `d_be`  in  4  byte enables.
- `d_gnt`  out  1  data request accepted.
- `d_rvalid`  out  1  load data, or store acknowledge.
- `d_rdata`  out  CPU_WIDTH  load data; 0 for stores.
- `m_req`, `m_we`  out  1  memory strobe and write enable.
- `m_addr`, `m_wdata`  out  CPU_WIDTH  memory address and write data.
- `m_be`  out  4  memory byte enables.
- `m_rdata`  in  CPU_WIDTH  memory read data, valid `MEM_LATENCY` cycles after `m_req`.

## Operation
- **FSM states:**
  - IDLE: no transaction outstanding.
  - WAIT: transaction outstanding, counter > 0.
  - RESP: response cycle.
- **Grant window:** a new grant may issue only in IDLE or RESP.
  - On grant, the FSM goes to WAIT with `cnt = MEM_LATENCY-1`.
  - If `MEM_LATENCY` = 1, the FSM goes directly to RESP.
  - With no new grant, RESP goes to IDLE.
  - WAIT decrements `cnt`; at 0 it moves to RESP.
- **Arbitration:** data wins by default, because it is the older instruction. IF wins when `if_req` is high and either:
  - `d_req` is low, or
  - `streak == STARVE_LIMIT`.
- **Starvation counter (`streak`):**
  - Increments, saturating at `STARVE_LIMIT`, on each data grant made while `if_req` = 1.
  - Clears on an IF grant.
  - Is unchanged on a data grant made while `if_req` = 0.
- **Grant cycle:** the `m_*` outputs drive the winner's fields combinationally and `m_req` = 1.
  - Otherwise `m_req`, `m_we` and `m_be` are 0, and `m_addr`/`m_wdata` are 0.
  - The owner is latched.
  - `gnt` is a single-cycle pulse to the winner; the loser holds its request.
- **RESP cycle:** the owner's `rvalid` = 1 and its `rdata` = `m_rdata` (`d_rdata` = 0 if a store). The non-owner's `rvalid`/`rdata` = 0.
- **Flush:**
  - `flush_if` high while the owner is IF (WAIT or RESP) sets the `drop` flag; its response is suppressed (`if_rvalid` = 0).
  - `flush_if` in the same cycle as an IF grant marks that new transaction dropped.
  - `drop` clears on leaving RESP.
  - Data transactions are never dropped.
- **Reset** (any time, including mid-transaction):
  - FSM → IDLE; `cnt`, `streak`, `drop` and the owner are cleared.
  - All outputs are 0.
  - The outstanding transaction is discarded and no `rvalid` follows the release of reset.

## Timing
- Request-to-grant latency is 0 cycles when idle.
- A grant in cycle t produces its response in cycle t+`MEM_LATENCY`.
- Back-to-back grants are possible in a RESP cycle, giving a throughput of one transaction per `MEM_LATENCY` cycles (every cycle when `MEM_LATENCY` = 1).
- `gnt` depends combinationally on `req`. `rvalid`/`rdata` depend combinationally on registered state and `m_rdata`.
- No combinational path runs from `flush_if` to `if_rvalid` in the same cycle except suppression during RESP. `if_rvalid` = `rvalid_raw & ~drop & ~(flush_if & owner_is_if)`.

## Structure
- **`kamacore_datatypes` package additions:**
  - `arb_state_e` {ARB_IDLE, ARB_WAIT, ARB_RESP}.
  - `mem_owner_e` {OWNER_NONE, OWNER_IF, OWNER_D}.
  - `MEM_BE_WIDTH` = 4.
- **Sub-module `kamacore_mem_arb_pick`:** combinational winner selection from `if_req`, `d_req` and `streak`.
- **In `kamacore_top`:**
  - `branch_valid` connects to `flush_if`.
  - `if_gnt`/`d_gnt` together with `rvalid` feed the pipeline-stage hold inputs.

## Test plan
- **Idle fetch:** `MEM_LATENCY` = 2, `if_req` at cycle 0 with `if_addr` = 0x100 → `if_gnt` at cycle 0; `if_rvalid` with `m_rdata` at cycle 2; FSM in IDLE at cycle 3.
- **Contention:** `if_req` and `d_req` (load 0x200) both high → data granted first; IF granted in the RESP cycle 2; `if_rvalid` at cycle 4.
- **Starvation:** `d_req` held with streams of loads, `if_req` held, `STARVE_LIMIT` = 3 → exactly 3 data grants, then an IF grant, then `streak` returns to 0.
- **Flush:** IF granted at cycle 0, `flush_if` at cycle 1 → no `if_rvalid` at cycle 2; a data request at cycle 2 is still granted.
- **Store:** `d_we` = 1, `d_be` = 4'b0011 → `m_we`/`m_be` match in the grant cycle; `d_rvalid` = 1 with `d_rdata` = 0 after `MEM_LATENCY` cycles.
- **Reset mid-WAIT:** `rst` low at cycle 1 of a fetch → all outputs 0 immediately; no `if_rvalid` after release; the first request after release is granted in the same cycle.
